// File: rtl/vector_reg_write_arbiter_if.sv
// Bundle between the requesting execution units and the vector register write arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface vector_reg_write_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int VECTOR_REG_DEPTH = 64,
    parameter int VECTOR_REG_WIDTH = 64
);
    localparam int AW = $clog2(VECTOR_REG_DEPTH);
    localparam int LW = AW + 1;

    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ*LW-1:0]               req_len;
    logic [NUM_REQ-1:0]                  elem_valid;
    logic [NUM_REQ*VECTOR_REG_WIDTH-1:0] elem_data;
    logic [NUM_REQ-1:0]                  grant;
    logic [NUM_REQ-1:0]                  elem_ready;
    logic [NUM_REQ-1:0]                  done;
    logic                                busy;
    logic                                write;
    logic [AW-1:0]                       write_addr;
    logic [VECTOR_REG_WIDTH-1:0]         write_data;

    modport master (
        output req, req_len, elem_valid, elem_data,
        input  grant, elem_ready, done, busy, write, write_addr, write_data
    );

    modport slave (
        input  req, req_len, elem_valid, elem_data,
        output grant, elem_ready, done, busy, write, write_addr, write_data
    );
endinterface

// File: rtl/vector_reg_write_arbiter.sv
// Burst-granular arbiter for the single write port of one vector register.
// Define VREG_ARB_FIXED_PRIORITY_EN for lowest-index-wins; default is round-robin.
module vector_reg_write_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int VECTOR_REG_DEPTH = 64,
    parameter int VECTOR_REG_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    vector_reg_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(VECTOR_REG_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                      r_state;
    logic [NUM_REQ-1:0]          r_grant;
    logic [NUM_REQ-1:0]          r_done;
    logic                        r_write;
    logic [AW-1:0]               r_write_addr;
    logic [VECTOR_REG_WIDTH-1:0] r_write_data;
    logic [AW-1:0]               r_idx;
    logic [LW-1:0]               r_len;
    logic [GW-1:0]               r_owner;

    logic [GW-1:0]               w_winner;
    logic                        w_any;
    logic [LW-1:0]               w_sel_len;
    logic [LW-1:0]               w_len;
    logic                        w_hs;
    logic                        w_last;
    logic [VECTOR_REG_WIDTH-1:0] w_owner_data;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] sel);
        onehot      = {NUM_REQ{1'b0}};
        onehot[sel] = 1'b1;
    endfunction

    function automatic logic [GW-1:0] fixed_pick(input logic [NUM_REQ-1:0] req_v);
        fixed_pick = {GW{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_v[k]) fixed_pick = GW'(k);
            else          fixed_pick = fixed_pick;
        end
    endfunction

    // Search upward from ptr with wrap; the first active request wins.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                              input logic [GW-1:0]      ptr);
        logic [GW:0] cand;
        logic        found;
        rr_pick = {GW{1'b0}};
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            cand = (cand >= (GW+1)'(NUM_REQ)) ? cand - (GW+1)'(NUM_REQ) : cand;
            if (!found && req_v[cand[GW-1:0]]) begin
                found   = 1'b1;
                rr_pick = cand[GW-1:0];
            end else begin
                found   = found;
            end
        end
    endfunction

`ifdef VREG_ARB_FIXED_PRIORITY_EN
    assign w_winner = fixed_pick(bus.req);
`else
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] w_next_ptr;
    assign w_winner   = rr_pick(bus.req, r_rr_ptr);
    assign w_next_ptr = (r_owner == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : r_owner + GW'(1);
`endif

    assign w_any        = |bus.req;
    assign w_sel_len    = bus.req_len[w_winner*LW +: LW];
    assign w_hs         = (r_state == ST_BURST) & bus.elem_valid[r_owner];
    assign w_last       = ({1'b0, r_idx} == (r_len - LW'(1)));
    assign w_owner_data = bus.elem_data[r_owner*VECTOR_REG_WIDTH +: VECTOR_REG_WIDTH];

    // Clamp the requested burst length to the register depth.
    always_comb begin
        w_len = w_sel_len;
        if (w_sel_len > LW'(VECTOR_REG_DEPTH)) w_len = LW'(VECTOR_REG_DEPTH);
        else                                   w_len = w_sel_len;
    end

    // Arbitration FSM with registered grant, done and register-file write outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= {NUM_REQ{1'b0}};
            r_done       <= {NUM_REQ{1'b0}};
            r_write      <= 1'b0;
            r_write_addr <= {AW{1'b0}};
            r_write_data <= {VECTOR_REG_WIDTH{1'b0}};
            r_idx        <= {AW{1'b0}};
            r_len        <= {LW{1'b0}};
            r_owner      <= {GW{1'b0}};
`ifndef VREG_ARB_FIXED_PRIORITY_EN
            r_rr_ptr     <= {GW{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_write <= 1'b0;
                    r_done  <= {NUM_REQ{1'b0}};
                    if (w_any) begin
                        r_owner <= w_winner;
                        r_len   <= w_len;
                        r_idx   <= {AW{1'b0}};
                        if (w_len == LW'(0)) begin
                            // Empty burst: skip straight to the done pulse.
                            r_state <= ST_FLUSH;
                            r_done  <= onehot(w_winner);
`ifndef VREG_ARB_FIXED_PRIORITY_EN
                            r_rr_ptr <= (w_winner == GW'(NUM_REQ - 1)) ? {GW{1'b0}}
                                                                       : w_winner + GW'(1);
`endif
                        end else begin
                            r_state <= ST_BURST;
                            r_grant <= onehot(w_winner);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        r_write      <= 1'b1;
                        r_write_addr <= r_idx;
                        r_write_data <= w_owner_data;
                        if (w_last) begin
                            r_state  <= ST_FLUSH;
                            r_grant  <= {NUM_REQ{1'b0}};
                            r_done   <= onehot(r_owner);
`ifndef VREG_ARB_FIXED_PRIORITY_EN
                            r_rr_ptr <= w_next_ptr;
`endif
                        end else begin
                            r_idx    <= r_idx + AW'(1);
                        end
                    end else begin
                        r_write <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_write <= 1'b0;
                    r_done  <= {NUM_REQ{1'b0}};
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {NUM_REQ{1'b0}};
                    r_done  <= {NUM_REQ{1'b0}};
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.elem_ready = (r_state == ST_BURST) ? r_grant : {NUM_REQ{1'b0}};
    assign bus.done       = r_done;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.write      = r_write;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
endmodule

// File: doc/vector_reg_write_arbiter.md
# vector_reg_write_arbiter

Shares the single write port of one vector register among `NUM_REQ` requesters (load unit, functional-unit pipes). A requester wins the port for a whole burst of `len` elements. The arbiter streams that burst into consecutive element addresses starting at 0 and drives `write`/`write_addr`/`write_data` of the vector register directly. Sits between the execution units and one vector register instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `VECTOR_REG_DEPTH`, 64, elements per vector register
- `VECTOR_REG_WIDTH`, 64, bits per element
- `AW`, derived: `$clog2(VECTOR_REG_DEPTH)`; `LW`, derived: `AW+1`

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester burst request
- `req_len`  in  NUM_REQ*LW  per-requester burst length, field i at `[i*LW +: LW]`
- `elem_valid`  in  NUM_REQ  element-valid per requester
- `elem_data`  in  NUM_REQ*VECTOR_REG_WIDTH  element data, field i at `[i*W +: W]`
- `grant`  out  NUM_REQ  one-hot owner of the port, registered
- `elem_ready`  out  NUM_REQ  equals `grant` while in BURST, else 0
- `done`  out  NUM_REQ  one-cycle pulse at the owner's final write
- `busy`  out  1  state != IDLE
- `write`  out  1  register-file write enable, registered
- `write_addr`  out  AW  element address, registered
- `write_data`  out  VECTOR_REG_WIDTH  element data, registered

## Operation
- States: IDLE, BURST, FLUSH.
- **IDLE:**
  - If any `req` is set, select winner `g`. Arbitration is round-robin, searching from `rr_ptr` upward with wrap.
  - Latch `len = req_len[g]`. Values above `VECTOR_REG_DEPTH` clamp to DEPTH.
  - Set `grant[g]`, clear `idx`, go to BURST.
  - If `len == 0`, go to FLUSH instead: no writes, `done[g]` pulses next cycle.
- **BURST:**
  - Handshake is `elem_valid[g] & elem_ready[g]`.
  - On each handshake: capture `write=1`, `write_addr=idx`, `write_data=elem_data[g]`, then `idx++`.
  - No handshake: `write=0`; `write_addr` and `write_data` hold their last values.
  - On the handshake where `idx == len-1`: go to FLUSH, clear `grant`, set `rr_ptr = g+1` (mod NUM_REQ).
- **FLUSH:**
  - The last write is on the bus and `done[g]=1`. Next state is IDLE.
- Other requesters' `req`, `elem_valid` and `elem_data` are ignored while not granted.
- The owner deasserting `req` mid-burst has no effect; the burst completes.
- A `req` still high in IDLE after `done` is a new request.
- `elem_valid` on non-owners never produces a write.
- `idx` never exceeds `len-1`, so `write_addr` wraps nowhere within a burst.
- Reset (any time, including mid-burst) forces:
  - IDLE, `rr_ptr=0`
  - `grant=0`, `elem_ready=0`, `done=0`, `busy=0`
  - `write=0`, `write_addr=0`, `write_data=0`
- A partially written vector is left as-is after reset; no write is in flight after reset.

## Timing
- Request to grant: 1 cycle. `req` is sampled in IDLE at edge N; `grant`/`elem_ready` are high from N+1.
- Element to register-file write: 1 cycle. The handshake at edge M gives `write=1` during cycle M+1, so the register file stores it at edge M+2.
- Full-rate burst of L elements:
  - `grant` high L cycles, `done` 1 cycle after the last handshake.
  - Next grant is possible 2 cycles after the last handshake (FLUSH, then IDLE).
- `done` coincides with the final `write=1` cycle. For `len==0`, `done` occurs with `write=0`.
- Round-robin fairness: with all requesters continuously requesting, each is granted once every NUM_REQ bursts.

## Configuration
- `VREG_ARB_FIXED_PRIORITY_EN`
  - **Defined:** lowest-index active `req` always wins. `rr_ptr` is not implemented.
  - **Undefined (default):** round-robin as above.

## Test plan
- Reset, then `req[1]=1`, `len=4`, `elem_valid[1]` held high with data 0xA0..0xA3 -> `grant=4'b0010` for 4 cycles; writes to addr 0..3 with 0xA0..0xA3; `done[1]` with the addr-3 write; `busy` low 2 cycles after the last handshake.
- `req=4'b1111` held, `len=2` each -> grant order 0,1,2,3,0. Under `VREG_ARB_FIXED_PRIORITY_EN`, order is 0,0,0.
- `len=64`, `elem_valid` toggling 1,0,1,0 -> 64 writes to addr 0..63 in order; `write=0` on idle cycles; addr and data hold.
- `len=0` on req[2] -> no `write`; `done[2]` 2 cycles after `req`; then req[3] is granted.
- `len=100` -> clamped; exactly 64 writes, final addr 63.
- Async reset asserted at element 10 of a 64-element burst -> all outputs 0 immediately. After release, `req[0]` is granted first and `write_addr` restarts at 0.
